// File: rtl/bytebasher_pkg.sv
// bytebasher_pkg
//   Definitions shared by the hit capture front end, the game control FSM
//   and the target generator: box code width, the "no hit" code, the number
//   of boxes and the hit capture FSM state encoding.
package bytebasher_pkg;

  localparam int BOX_W = 4;
  localparam logic [BOX_W-1:0] NO_HIT = 4'd0;
  localparam int NUM_BOXES = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_QUALIFY = 3'd2,
    ST_HELD    = 3'd3,
    ST_RELEASE = 3'd4
  } hit_state_e;

  // True for a code that names a real box (1..max_box); 0 and anything
  // above max_box are treated as bus noise.
  function automatic logic box_in_range(input logic [BOX_W-1:0] code,
                                        input int max_box);
    return (code != NO_HIT) && (int'(code) <= max_box);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a bus of independent asynchronous bits. Each
//   bit is synchronized on its own; any skew between bits must be absorbed
//   by whatever consumes the bus.
// Ports
//   clk     in  1      destination clock
//   resetn  in  1      asynchronous active-low reset, flops clear to 0
//   i_d     in  WIDTH  asynchronous input
//   o_q     out WIDTH  synchronized output, two clk edges of latency
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hit_capture.sv
// hit_capture
//   Synchronizes and debounces the 4-bit box code from the sensor GPIO bus
//   and presents each confirmed hit once as a held valid/address pair for the
//   control FSM. A debounced release to code 0 is required before re-arming.
// Ports
//   clk            in  1  system clock
//   resetn         in  1  asynchronous active-low reset
//   i_enable       in  1  game active; low forces IDLE
//   i_box_raw      in  4  raw box code (asynchronous), 0 = no hit
//   i_hit_ack      in  1  control FSM consumed the pending hit
//   o_hit_valid    out 1  confirmed hit pending
//   o_box_address  out 4  box of the pending hit
//   o_overrun      out 1  sticky: hit confirmed while previous still pending
//   o_press_count  out 8  confirmed hits since enable rose (wraps)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | game disabled, debounce counter held at 0
// ARMED   | waiting for a legal non-zero code
// QUALIFY | candidate code seen, counting consecutive stable samples
// HELD    | hit confirmed, waiting for the code to return to 0
// RELEASE | code is 0, counting stable samples before re-arming
module hit_capture #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_BOXES       = bytebasher_pkg::NUM_BOXES
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             i_enable,
  input  logic [bytebasher_pkg::BOX_W-1:0] i_box_raw,
  input  logic                             i_hit_ack,
  output logic                             o_hit_valid,
  output logic [bytebasher_pkg::BOX_W-1:0] o_box_address,
  output logic                             o_overrun,
  output logic [7:0]                       o_press_count
);

  import bytebasher_pkg::*;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  hit_state_e       r_state;
  hit_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [BOX_W-1:0] r_cand;
  logic [BOX_W-1:0] w_s;

  logic             r_hit_valid;
  logic [BOX_W-1:0] r_box_address;
  logic             r_overrun;
  logic [7:0]       r_press_count;

  logic w_cnt_clr;
  logic w_cnt_load1;
  logic w_cnt_inc;
  logic w_cand_load;
  logic w_confirm;
  logic w_leave_idle;
  logic w_accept;
  logic w_s_legal;
  logic w_s_zero;
  logic w_s_match;
  logic w_cnt_last;

  sync_2ff #(.WIDTH(BOX_W)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (i_box_raw),
    .o_q    (w_s)
  );

  assign w_s_legal  = box_in_range(w_s, NUM_BOXES);
  assign w_s_zero   = (w_s == NO_HIT);
  assign w_s_match  = (w_s == r_cand);
  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_state_nxt = ST_ARMED;
        ST_ARMED:   if (w_s_legal) w_state_nxt = ST_QUALIFY;
        ST_QUALIFY: begin
          if (!w_s_match)      w_state_nxt = ST_ARMED;
          else if (w_cnt_last) w_state_nxt = ST_HELD;
        end
        ST_HELD:    if (w_s_zero) w_state_nxt = ST_RELEASE;
        ST_RELEASE: begin
          if (!w_s_zero)       w_state_nxt = ST_HELD;
          else if (w_cnt_last) w_state_nxt = ST_ARMED;
        end
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_clr    = 1'b0;
    w_cnt_load1  = 1'b0;
    w_cnt_inc    = 1'b0;
    w_cand_load  = 1'b0;
    w_confirm    = 1'b0;
    w_leave_idle = 1'b0;
    if (!i_enable) begin
      w_cnt_clr = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_clr    = 1'b1;
          w_leave_idle = 1'b1;
        end
        ST_ARMED: begin
          if (w_s_legal) begin
            w_cand_load = 1'b1;
            w_cnt_load1 = 1'b1;
          end
        end
        ST_QUALIFY: begin
          if (w_s_match) begin
            if (w_cnt_last) w_confirm = 1'b1;
            else            w_cnt_inc = 1'b1;
          end
        end
        ST_HELD:    if (w_s_zero) w_cnt_load1 = 1'b1;
        ST_RELEASE: if (w_s_zero && !w_cnt_last) w_cnt_inc = 1'b1;
        default:    w_cnt_clr = 1'b1;
      endcase
    end
  end

  // A confirm is delivered when the slot is free or being freed on this
  // same edge; otherwise the pending hit is kept and the loss is flagged.
  assign w_accept = w_confirm && (!r_hit_valid || i_hit_ack);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_cand <= NO_HIT;
    end else begin
      if (w_cnt_clr)        r_cnt <= '0;
      else if (w_cnt_load1) r_cnt <= CNT_ONE;
      else if (w_cnt_inc)   r_cnt <= r_cnt + CNT_ONE;
      if (w_cand_load) r_cand <= w_s;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hit_valid   <= 1'b0;
      r_box_address <= NO_HIT;
      r_overrun     <= 1'b0;
      r_press_count <= 8'd0;
    end else begin
      if (!i_enable) begin
        r_hit_valid <= 1'b0;
      end else if (w_accept) begin
        r_hit_valid   <= 1'b1;
        r_box_address <= r_cand;
      end else if (r_hit_valid && i_hit_ack) begin
        r_hit_valid <= 1'b0;
      end

      if (w_leave_idle)                r_overrun <= 1'b0;
      else if (w_confirm && !w_accept) r_overrun <= 1'b1;

      if (w_leave_idle)  r_press_count <= 8'd0;
      else if (w_accept) r_press_count <= r_press_count + 8'd1;
    end
  end

  assign o_hit_valid   = r_hit_valid;
  assign o_box_address = r_box_address;
  assign o_overrun     = r_overrun;
  assign o_press_count = r_press_count;

endmodule

// File: tb/tb_hit_capture.sv
// tb_hit_capture
//   Directed bench for hit_capture with a debounce length of 4 samples.
module tb_hit_capture;
  import bytebasher_pkg::*;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       i_enable;
  logic [3:0] i_box_raw;
  logic       i_hit_ack;
  logic       o_hit_valid;
  logic [3:0] o_box_address;
  logic       o_overrun;
  logic [7:0] o_press_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hit_capture #(.DEBOUNCE_CYCLES(DEB), .NUM_BOXES(9)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_enable      (i_enable),
    .i_box_raw     (i_box_raw),
    .i_hit_ack     (i_hit_ack),
    .o_hit_valid   (o_hit_valid),
    .o_box_address (o_box_address),
    .o_overrun     (o_overrun),
    .o_press_count (o_press_count)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; i_enable = 1'b1; i_box_raw = 4'd3; i_hit_ack = 1'b0;
    step(3);
    n_checks++; if (o_hit_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b want 0", o_hit_valid); end
    n_checks++; if (o_box_address !== 4'd0) begin n_errors++; $display("FAIL rst_addr: got %0d want 0", o_box_address); end
    n_checks++; if (o_overrun !== 1'b0) begin n_errors++; $display("FAIL rst_overrun: got %b want 0", o_overrun); end
    n_checks++; if (o_press_count !== 8'd0) begin n_errors++; $display("FAIL rst_count: got %0d want 0", o_press_count); end
    n_checks++; if (dut.r_state !== ST_IDLE) begin n_errors++; $display("FAIL rst_state: got %0d want %0d", dut.r_state, ST_IDLE); end
    resetn = 1'b1;
    step(5);
    n_checks++; if (o_hit_valid !== 1'b0) begin n_errors++; $display("FAIL rst_press_early: got %b want 0", o_hit_valid); end
    step(1);
    n_checks++; if (o_hit_valid !== 1'b1) begin n_errors++; $display("FAIL rst_press_valid: got %b want 1", o_hit_valid); end
    n_checks++; if (o_box_address !== 4'd3) begin n_errors++; $display("FAIL rst_press_addr: got %0d want 3", o_box_address); end
    n_checks++; if (o_press_count !== 8'd1) begin n_errors++; $display("FAIL rst_press_count: got %0d want 1", o_press_count); end
    i_hit_ack = 1'b1;
    step(1);
    i_hit_ack = 1'b0;
    n_checks++; if (o_hit_valid !== 1'b0) begin n_errors++; $display("FAIL rst_ack: got %b want 0", o_hit_valid); end
    i_box_raw = 4'd0;
    step(5);
    n_checks++; if (dut.r_state !== ST_RELEASE) begin n_errors++; $display("FAIL rearm_early: got %0d want %0d", dut.r_state, ST_RELEASE); end
    step(1);
    n_checks++; if (dut.r_state !== ST_ARMED) begin n_errors++; $display("FAIL rearm: got %0d want %0d", dut.r_state, ST_ARMED); end
  endtask

  task automatic test_bounce;
    i_box_raw = 4'd5; step(1);
    i_box_raw = 4'd0; step(1);
    i_box_raw = 4'd5; step(1);
    i_box_raw = 4'd7; step(1);
    i_box_raw = 4'd5;
    step(5);
    n_checks++; if (o_hit_valid !== 1'b0) begin n_errors++; $display("FAIL bounce_early: got %b want 0", o_hit_valid); end
    step(1);
    n_checks++; if (o_hit_valid !== 1'b1) begin n_errors++; $display("FAIL bounce_valid: got %b want 1", o_hit_valid); end
    n_checks++; if (o_box_address !== 4'd5) begin n_errors++; $display("FAIL bounce_addr: got %0d want 5", o_box_address); end
    step(10);
    n_checks++; if (o_press_count !== 8'd2) begin n_errors++; $display("FAIL bounce_once: got count %0d want 2", o_press_count); end
    i_hit_ack = 1'b1; step(1); i_hit_ack = 1'b0;
    n_checks++; if (o_hit_valid !== 1'b0) begin n_errors++; $display("FAIL bounce_ack: got %b want 0", o_hit_valid); end
    i_box_raw = 4'd0;
    step(6);
  endtask

  task automatic test_out_of_range;
    i_box_raw = 4'd12;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n_checks++; if (o_hit_valid !== 1'b0 || dut.r_state !== ST_ARMED) begin
        n_errors++;
        $display("FAIL range_cycle%0d: got valid %b state %0d want valid 0 state %0d", i, o_hit_valid, dut.r_state, ST_ARMED);
      end
    end
    i_box_raw = 4'd0;
    step(3);
    n_checks++; if (o_press_count !== 8'd2) begin n_errors++; $display("FAIL range_count: got %0d want 2", o_press_count); end
  endtask

  task automatic test_overrun;
    i_box_raw = 4'd2;
    step(6);
    n_checks++; if (o_hit_valid !== 1'b1 || o_box_address !== 4'd2) begin n_errors++; $display("FAIL ovr_first: got valid %b addr %0d want 1/2", o_hit_valid, o_box_address); end
    i_box_raw = 4'd0;
    step(6);
    i_box_raw = 4'd6;
    step(5);
    n_checks++; if (o_overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_early: got %b want 0", o_overrun); end
    step(1);
    n_checks++; if (o_overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_flag: got %b want 1", o_overrun); end
    n_checks++; if (o_hit_valid !== 1'b1 || o_box_address !== 4'd2) begin n_errors++; $display("FAIL ovr_kept: got valid %b addr %0d want 1/2", o_hit_valid, o_box_address); end
    n_checks++; if (o_press_count !== 8'd3) begin n_errors++; $display("FAIL ovr_count: got %0d want 3", o_press_count); end
    i_hit_ack = 1'b1; step(1); i_hit_ack = 1'b0;
    n_checks++; if (o_hit_valid !== 1'b0 || o_overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_ack: got valid %b overrun %b want 0/1", o_hit_valid, o_overrun); end
    i_box_raw = 4'd0;
    step(6);
  endtask

  task automatic test_disable;
    i_box_raw = 4'd9;
    step(6);
    n_checks++; if (o_hit_valid !== 1'b1 || o_press_count !== 8'd4) begin n_errors++; $display("FAIL dis_press: got valid %b count %0d want 1/4", o_hit_valid, o_press_count); end
    i_box_raw = 4'd0;
    step(6);
    i_box_raw = 4'd4;
    step(3);
    n_checks++; if (dut.r_state !== ST_QUALIFY) begin n_errors++; $display("FAIL dis_qualify: got %0d want %0d", dut.r_state, ST_QUALIFY); end
    i_enable = 1'b0; i_box_raw = 4'd0;
    step(1);
    n_checks++; if (dut.r_state !== ST_IDLE) begin n_errors++; $display("FAIL dis_state: got %0d want %0d", dut.r_state, ST_IDLE); end
    n_checks++; if (o_hit_valid !== 1'b0) begin n_errors++; $display("FAIL dis_valid: got %b want 0", o_hit_valid); end
    n_checks++; if (dut.r_cnt !== 2'd0) begin n_errors++; $display("FAIL dis_cnt: got %0d want 0", dut.r_cnt); end
    n_checks++; if (o_box_address !== 4'd9 || o_overrun !== 1'b1 || o_press_count !== 8'd4) begin
      n_errors++; $display("FAIL dis_readback: got addr %0d ovr %b count %0d want 9/1/4", o_box_address, o_overrun, o_press_count);
    end
    step(3);
    i_enable = 1'b1;
    step(1);
    n_checks++; if (dut.r_state !== ST_ARMED) begin n_errors++; $display("FAIL reen_state: got %0d want %0d", dut.r_state, ST_ARMED); end
    n_checks++; if (o_press_count !== 8'd0 || o_overrun !== 1'b0) begin n_errors++; $display("FAIL reen_clear: got count %0d ovr %b want 0/0", o_press_count, o_overrun); end
  endtask

  task automatic test_ack_coincident;
    i_box_raw = 4'd1;
    step(6);
    n_checks++; if (o_hit_valid !== 1'b1 || o_box_address !== 4'd1 || o_press_count !== 8'd1) begin
      n_errors++; $display("FAIL coin_first: got valid %b addr %0d count %0d want 1/1/1", o_hit_valid, o_box_address, o_press_count);
    end
    i_box_raw = 4'd0;
    step(6);
    i_box_raw = 4'd8;
    step(5);
    i_hit_ack = 1'b1;
    step(1);
    i_hit_ack = 1'b0;
    n_checks++; if (o_hit_valid !== 1'b1 || o_box_address !== 4'd8) begin n_errors++; $display("FAIL coin_set_wins: got valid %b addr %0d want 1/8", o_hit_valid, o_box_address); end
    n_checks++; if (o_overrun !== 1'b0 || o_press_count !== 8'd2) begin n_errors++; $display("FAIL coin_flags: got ovr %b count %0d want 0/2", o_overrun, o_press_count); end
    step(1);
    n_checks++; if (o_hit_valid !== 1'b1) begin n_errors++; $display("FAIL coin_hold: got %b want 1", o_hit_valid); end
    i_hit_ack = 1'b1; step(1); i_hit_ack = 1'b0;
    n_checks++; if (o_hit_valid !== 1'b0) begin n_errors++; $display("FAIL coin_ack: got %b want 0", o_hit_valid); end
    i_box_raw = 4'd0;
    step(6);
  endtask

  task automatic test_async_reset;
    i_box_raw = 4'd5;
    step(4);
    n_checks++; if (dut.r_state !== ST_QUALIFY) begin n_errors++; $display("FAIL arst_pre: got %0d want %0d", dut.r_state, ST_QUALIFY); end
    resetn = 1'b0;
    #2;
    n_checks++; if (dut.r_state !== ST_IDLE || dut.r_cnt !== 2'd0) begin n_errors++; $display("FAIL arst_state: got state %0d cnt %0d want %0d/0", dut.r_state, dut.r_cnt, ST_IDLE); end
    n_checks++; if (o_box_address !== 4'd0 || o_press_count !== 8'd0 || o_hit_valid !== 1'b0) begin
      n_errors++; $display("FAIL arst_outputs: got addr %0d count %0d valid %b want 0/0/0", o_box_address, o_press_count, o_hit_valid);
    end
    step(1);
    resetn = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_out_of_range();
    test_overrun();
    test_disable();
    test_ack_coincident();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hit_capture.md
# hit_capture

Front-end stage between the Arduino box-sensor GPIO bus and the game control FSM. Synchronizes the 4-bit raw box code, debounces it, and presents each confirmed hit exactly once as a held `o_hit_valid`/`o_box_address` pair that the control FSM acknowledges. Requires a debounced release to code 0 before re-arming, so one physical whack produces one hit event.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive synchronized cycles a code must hold to confirm a press or a release (10 ms at 50 MHz); minimum 2.
- `NUM_BOXES`, 9: highest legal box code; codes above this are noise.
- `clk` in 1: system clock, 50 MHz.
- `resetn` in 1: reset, asynchronous, active-low.
- `i_enable` in 1: game active; low forces IDLE.
- `i_box_raw` in 4: raw Arduino code, asynchronous; 0 means no hit.
- `i_hit_ack` in 1: control FSM consumed the hit; sampled only while `o_hit_valid` is high.
- `o_hit_valid` out 1: confirmed hit pending.
- `o_box_address` out 4: box of the pending hit; stable while `o_hit_valid` is high.
- `o_overrun` out 1: sticky; a hit was confirmed while the previous one was still unacknowledged.
- `o_press_count` out 8: confirmed hits since enable rose; wraps 255→0.

## Operation
- Two-flop synchronizer on every `i_box_raw` bit gives `s`. Bit skew is absorbed by the stability requirement.
- FSM states: IDLE, ARMED, QUALIFY, HELD, RELEASE.
- IDLE: counters are cleared. Goes to ARMED when `i_enable`=1. Any state goes to IDLE when `i_enable`=0. Leaving IDLE clears `o_overrun` and `o_press_count`.
- ARMED: if `s` is in 1..NUM_BOXES, latch `cand`=`s`, set `cnt`=1, and go to QUALIFY. Out-of-range or 0 codes are ignored.
- QUALIFY:
  - `s`≠`cand`: go to ARMED. An immediate new candidate is not taken on this edge.
  - `s`==`cand` and `cnt`==DEBOUNCE_CYCLES-1: confirm and go to HELD.
  - Otherwise: `cnt`+1.
- Confirm:
  - If `o_hit_valid` is 0, or `i_hit_ack` is 1 on the same edge: `o_box_address`←`cand`, `o_hit_valid`←1, `o_press_count`+1.
  - Else: `o_overrun`←1. The pending address and valid are untouched and the count is not incremented.
- HELD: `s`==0 sets `cnt`=1 and goes to RELEASE. Any non-zero `s` keeps HELD.
- RELEASE:
  - `s`≠0: back to HELD.
  - `cnt`==DEBOUNCE_CYCLES-1 with `s`==0: go to ARMED.
  - Otherwise: `cnt`+1.
- Handshake: `o_hit_valid` falls on the edge where `i_hit_ack`=1 while valid, unless a confirm occurs on that same edge (set wins). Ack while valid is low is ignored. Acknowledgement is independent of FSM state.
- `i_enable` falling clears `o_hit_valid` and `cnt`. It keeps `o_box_address`, `o_overrun` and `o_press_count` for readback until the next enable.
- `cnt` is $clog2(DEBOUNCE_CYCLES) bits wide and never exceeds DEBOUNCE_CYCLES-1.

## Timing
- Reset values: all outputs 0, FSM in IDLE, synchronizer flops 0, `cnt` 0, `cand` 0.
- Press latency: with `i_box_raw` steady at legal code C from edge e, in ARMED, `o_hit_valid` is high after edge e+1+DEBOUNCE_CYCLES. Edges e and e+1 are synchronizer fill; edges e+2 … e+1+DEBOUNCE_CYCLES are DEBOUNCE_CYCLES stable samples.
- Ack to valid low: one edge.
- Re-arm: from raw 0 steady at edge r, the FSM is in ARMED after edge r+1+DEBOUNCE_CYCLES.
- Minimum press-to-press spacing: 2·DEBOUNCE_CYCLES+4 cycles.
- `resetn` asserted mid-operation clears state immediately. There is no partial-hit output after release.

## Structure
- Shared package `bytebasher_pkg`:
  - `BOX_W`=4
  - `NO_HIT`=4'd0
  - `NUM_BOXES`=9
  - FSM state typedef (3-bit encoding)
- The package is shared with the control FSM and the target generator.
- Sub-module `sync_2ff` (parameter WIDTH) for the synchronizer. It is reused for KEY inputs elsewhere.
- The debounce FSM, counters and handshake live in `hit_capture`.

## Test plan
Use DEBOUNCE_CYCLES=4 in simulation.
- Reset/enable: reset with enable=1 and raw=4'd3 → all outputs 0 during reset. After release, valid is high 5 edges after the first sampled raw=3, with address=3 and count=1.
- Bounce: raw toggles 5,0,5,7 at 1-cycle intervals, then 5 steady → exactly one valid with address=5, only after 4 stable samples of 5.
- Out of range: raw=4'd12 held 20 cycles → no valid, FSM never leaves ARMED/QUALIFY.
- Handshake/overrun: confirm hit 2 with no ack, release, press 6 → valid stays high with address=2, overrun=1, count=1. Ack → valid 0.
- Ack coincident with confirm: ack on the confirm edge of press 8 → valid stays 1, address=8, overrun=0.
- Disable mid-qualify: enable drops while in QUALIFY → valid 0, FSM IDLE. Re-enable with raw=0 → count=0 and overrun=0.
